uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
- Control stage directly upstream of the UART Tx shift register.
- Accepts one byte per valid/ready handshake and holds it stable on the data output to the shift register.
- Generates a single-cycle load pulse, then one shift-enable pulse per bit period across a 10-bit frame (start, 8 data LSB-first, stop), at 115200 baud.
- Reports busy/done to the byte source.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate in bits/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (truncating, 434 at defaults), derived localparam, clock cycles per bit period; must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  source presents a byte on i_data.
- i_data  input  8  byte to transmit.
- o_ready  output  1  block accepts a byte this cycle.
- o_tx_d  output  8  held byte, to shift register parallel input.
- o_load  output  1  one-cycle pulse: shift register loads {1, o_tx_d, 0}.
- o_shift_en  output  1  one-cycle pulse at the end of each bit period.
- o_busy  output  1  frame in progress.
- o_done  output  1  one-cycle pulse when the frame's final bit period ends.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state IDLE, baud_cnt 0, bit_cnt 0, o_tx_d 8'h00, o_load 0, o_shift_en 0, o_done 0, o_busy 0, o_ready 1.
- Reset mid-frame: the frame aborts immediately. No o_done is issued. State returns to IDLE.
- FSM states: IDLE, LOAD, SEND.
- IDLE:
  - o_ready = 1.
  - On a clock edge with i_valid=1: o_tx_d <= i_data, state -> LOAD.
  - With i_valid=0 the block stays in IDLE.
- LOAD (exactly 1 cycle):
  - o_load = 1, o_busy = 1, o_ready = 0.
  - Next edge: state -> SEND, baud_cnt = 0, bit_cnt = 0.
- SEND:
  - baud_cnt increments every cycle.
  - When baud_cnt == CLKS_PER_BIT-1: o_shift_en = 1 for that cycle, baud_cnt wraps to 0, bit_cnt increments.
  - The first bit period (start bit) is CLKS_PER_BIT cycles, measured from the edge that ends LOAD.
- Frame end:
  - The 10th o_shift_en pulse (bit_cnt == 9 with baud_cnt == CLKS_PER_BIT-1) coincides with o_done = 1.
  - Next edge: state -> IDLE, so o_ready = 1 one cycle after o_done.
- Frame timing:
  - Handshake edge to return to IDLE: 1 + 10*CLKS_PER_BIT cycles.
  - Minimum back-to-back frame period: 10*CLKS_PER_BIT + 2 cycles.
- o_busy = 1 in LOAD and SEND.
- Output decode: o_load, o_shift_en, o_done, o_ready and o_busy are decoded from registered state and counters only. There is no combinational path from any input to any output.
- o_tx_d stability: held from the capture edge until the next accepted handshake. Changes on i_data after capture have no effect.
- Handshake rules:
  - i_valid while o_ready=0 is ignored; the source must hold i_valid and i_data until accepted.
  - i_valid asserted in the same cycle as o_done is not accepted; acceptance happens in the following IDLE cycle.
- Widths:
  - baud_cnt is $clog2(CLKS_PER_BIT) bits.
  - bit_cnt is 4 bits and never exceeds 9.
- Line behaviour: the 10th shift fills the shift register with 1, so the line stays idle-high after the stop bit.

Decomposition:
- Shared package uart_pkg holds:
  - default CLK_FREQ and BAUD_RATE;
  - FRAME_BITS = 10;
  - DATA_BITS = 8;
  - FSM state encoding (IDLE = 2'd0, LOAD = 2'd1, SEND = 2'd2).
- One sub-module, uart_baud_cnt:
  - parameterised by CLKS_PER_BIT;
  - clear and enable inputs;
  - one-cycle tick output at terminal count;
  - reused later by the Rx path.

Test Plan:
- All scenarios use CLK_FREQ=460800, BAUD_RATE=115200, giving CLKS_PER_BIT=4.
- Single byte:
  - Stimulus: i_data=8'hA5, i_valid=1 accepted at edge 0.
  - Expected: o_load=1 in cycle 1; o_shift_en=1 in cycles 5,9,...,41 (10 pulses); o_done=1 in cycle 41 only; o_ready=1 from cycle 42.
  - With the shift register attached, serial bits per period are 0,1,0,1,0,0,1,0,1,1.
- Busy rejection:
  - Stimulus: i_data=8'h3C with i_valid held during the 8'hA5 frame.
  - Expected: no second o_load until cycle 43; o_tx_d stays 8'hA5 until the edge at cycle 42.
- Back-to-back:
  - Stimulus: 8'h00 then 8'hFF, i_valid held continuously.
  - Expected: o_load pulses exactly 42 cycles apart; 8'hFF serialises as 0,1,1,1,1,1,1,1,1,1.
- Reset mid-frame:
  - Stimulus: assert rst asynchronously in cycle 20 of a frame.
  - Expected: o_shift_en, o_busy and o_done drop at once, o_ready=1, no o_done pulse; the next byte sends a full correct frame.
- Data capture isolation:
  - Stimulus: change i_data every cycle after acceptance of 8'h5A.
  - Expected: o_tx_d remains 8'h5A for the whole frame.
- Idle hold:
  - Stimulus: i_valid=0 for 100 cycles after reset.
  - Expected: o_load, o_shift_en and o_done stay 0; o_ready stays 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default line rates, frame geometry and Tx FSM encoding.
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEF  = 50_000_000;
  localparam int unsigned BAUD_RATE_DEF = 115200;
  localparam int unsigned FRAME_BITS    = 10;
  localparam int unsigned DATA_BITS     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte-source handshake and shift-register control bundle for the UART Tx control stage.
interface uart_tx_ctrl_if;
  import uart_pkg::*;

  logic                 i_valid;
  logic [DATA_BITS-1:0] i_data;
  logic                 o_ready;
  logic [DATA_BITS-1:0] o_tx_d;
  logic                 o_load;
  logic                 o_shift_en;
  logic                 o_busy;
  logic                 o_done;

  modport master (
    output i_valid, i_data,
    input  o_ready, o_tx_d, o_load, o_shift_en, o_busy, o_done
  );

  modport slave (
    input  i_valid, i_data,
    output o_ready, o_tx_d, o_load, o_shift_en, o_busy, o_done
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts while enabled, wraps at CLKS_PER_BIT-1 and flags that cycle.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick_c = en && (cnt_q == TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == TERM) ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART Tx control: captures one byte per handshake, pulses load, then paces 10 shift enables.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = CLK_FREQ_DEF,
  parameter int unsigned BAUD_RATE = BAUD_RATE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_ctrl_if.slave bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned BIT_CNT_W    = 4;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [DATA_BITS-1:0] tx_d_q;
  logic                 baud_clr_c, baud_en_c, tick_c, last_bit_c;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (baud_clr_c),
    .en    (baud_en_c),
    .tick_c(tick_c)
  );

  assign last_bit_c = (bit_cnt_q == LAST_BIT);
  assign bus.o_tx_d = tx_d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and output decode, from registered state and counters only.
  always_comb begin
    state_d        = state_q;
    baud_clr_c     = 1'b0;
    baud_en_c      = 1'b0;
    bus.o_ready    = 1'b0;
    bus.o_load     = 1'b0;
    bus.o_busy     = 1'b0;
    bus.o_shift_en = 1'b0;
    bus.o_done     = 1'b0;
    case (state_q)
      IDLE: begin
        bus.o_ready = 1'b1;
        if (bus.i_valid) state_d = LOAD;
      end
      LOAD: begin
        bus.o_load = 1'b1;
        bus.o_busy = 1'b1;
        baud_clr_c = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        bus.o_busy     = 1'b1;
        baud_en_c      = 1'b1;
        bus.o_shift_en = tick_c;
        bus.o_done     = tick_c && last_bit_c;
        if (tick_c && last_bit_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit index within the frame; restarts on every load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
    end else if (state_q == LOAD) begin
      bit_cnt_q <= '0;
    end else if (tick_c) begin
      bit_cnt_q <= last_bit_c ? '0 : bit_cnt_q + BIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_d_q <= '0;
    end else if ((state_q == IDLE) && bus.i_valid) begin
      tx_d_q <= bus.i_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl at 4 clocks per bit, with a model of the downstream shift register.
module tb_uart_tx_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   load_cyc = 0;
  int   prev_load = 0;
  logic done_seen;

  uart_tx_ctrl_if bus ();

  uart_tx_ctrl #(
    .CLK_FREQ (460800),
    .BAUD_RATE(115200)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on the negedge just before the accepting edge; walks cycles 1..42 of the frame.
  task automatic frame_check(input string tag, input logic [7:0] exp_d, input logic [9:0] exp_bits,
                             input logic next_valid, input logic [7:0] next_d, input bit scramble);
    int bad_load = 0, bad_shift = 0, bad_done = 0, bad_busy = 0, bad_ready = 0, bad_d = 0;
    int nshift = 0;
    logic [9:0] sr  = '1;
    logic [9:0] got = '0;
    logic e_load, e_shift, e_done, e_busy, e_ready;
    for (int rel = 1; rel <= 42; rel++) begin
      @(negedge clk);
      e_load  = (rel == 1);
      e_shift = (rel >= 5) && (rel <= 41) && (((rel - 1) % 4) == 0);
      e_done  = (rel == 41);
      e_busy  = (rel <= 41);
      e_ready = (rel == 42);
      if (bus.o_load     !== e_load)  bad_load++;
      if (bus.o_shift_en !== e_shift) bad_shift++;
      if (bus.o_done     !== e_done)  bad_done++;
      if (bus.o_busy     !== e_busy)  bad_busy++;
      if (bus.o_ready    !== e_ready) bad_ready++;
      if (bus.o_tx_d     !== exp_d)   bad_d++;
      if (bus.o_load) begin
        sr = {1'b1, bus.o_tx_d, 1'b0};
        load_cyc = cyc;
      end
      if (bus.o_shift_en) begin
        got = {sr[0], got[9:1]};
        sr  = {1'b1, sr[9:1]};
        nshift++;
      end
      if (scramble) begin
        bus.i_valid = (rel <= 40);
        if (rel <= 40) bus.i_data = 8'($urandom);
      end else if (rel == 1) begin
        bus.i_valid = next_valid;
        bus.i_data  = next_d;
      end
    end
    chk({tag, " load_cycles"},  32'(bad_load),  32'd0);
    chk({tag, " shift_cycles"}, 32'(bad_shift), 32'd0);
    chk({tag, " done_cycles"},  32'(bad_done),  32'd0);
    chk({tag, " busy_cycles"},  32'(bad_busy),  32'd0);
    chk({tag, " ready_cycles"}, 32'(bad_ready), 32'd0);
    chk({tag, " tx_d_hold"},    32'(bad_d),     32'd0);
    chk({tag, " shift_count"},  32'(nshift),    32'd10);
    chk({tag, " serial_bits"},  32'(got),       32'(exp_bits));
  endtask

  initial begin
    int bad_idle;
    bus.i_valid = 1'b0;
    bus.i_data  = 8'h00;

    // Reset state
    @(negedge clk);
    chk("rst ready", 32'(bus.o_ready),    32'd1);
    chk("rst load",  32'(bus.o_load),     32'd0);
    chk("rst shift", 32'(bus.o_shift_en), 32'd0);
    chk("rst done",  32'(bus.o_done),     32'd0);
    chk("rst busy",  32'(bus.o_busy),     32'd0);
    chk("rst tx_d",  32'(bus.o_tx_d),     32'h00);
    rst = 1'b0;

    // Idle hold
    bad_idle = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.o_load || bus.o_shift_en || bus.o_done || !bus.o_ready) bad_idle++;
    end
    chk("idle hold", 32'(bad_idle), 32'd0);

    // Single byte A5, with 3C held pending; then 00 and FF back-to-back
    bus.i_valid = 1'b1;
    bus.i_data  = 8'hA5;
    frame_check("a5", 8'hA5, 10'b1101001010, 1'b1, 8'h3C, 1'b0);
    frame_check("3c", 8'h3C, 10'b1001111000, 1'b1, 8'h00, 1'b0);
    frame_check("00", 8'h00, 10'b1000000000, 1'b1, 8'hFF, 1'b0);
    prev_load = load_cyc;
    frame_check("ff", 8'hFF, 10'b1111111110, 1'b0, 8'h00, 1'b0);
    chk("b2b load gap", 32'(load_cyc - prev_load), 32'd42);

    // Data capture isolation
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h5A;
    frame_check("5a", 8'h5A, 10'b1010110100, 1'b0, 8'h00, 1'b1);

    // Reset mid-frame in cycle 20
    bus.i_valid = 1'b1;
    bus.i_data  = 8'hC3;
    done_seen   = 1'b0;
    for (int rel = 1; rel <= 20; rel++) begin
      @(negedge clk);
      if (rel == 1) bus.i_valid = 1'b0;
      done_seen = done_seen | bus.o_done;
    end
    chk("abort busy before", 32'(bus.o_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort busy",  32'(bus.o_busy),     32'd0);
    chk("abort shift", 32'(bus.o_shift_en), 32'd0);
    chk("abort done",  32'(bus.o_done),     32'd0);
    chk("abort ready", 32'(bus.o_ready),    32'd1);
    @(negedge clk);
    done_seen = done_seen | bus.o_done;
    rst = 1'b0;
    chk("abort no done", 32'(done_seen), 32'd0);
    bus.i_valid = 1'b1;
    bus.i_data  = 8'hC3;
    frame_check("c3", 8'hC3, 10'b1110000110, 1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
